// File: rtl/prog_fetch_pkg.sv
// Shared definitions for the program-ROM fetch sequencer and the decoder.
// Latency: n/a (types, constants and a pure helper function).
// Backpressure: n/a.
package prog_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_CHK,
        S_FETCH2,
        S_CHK2,
        S_VALID
    } state_t;

    // LDS/STS and JMP/CALL carry a second 16-bit word (address or target).
    localparam logic [15:0] LDS_STS_MASK   = 16'hFC0F;
    localparam logic [15:0] LDS_STS_MATCH  = 16'h9000;
    localparam logic [15:0] JMP_CALL_MASK  = 16'hFE0C;
    localparam logic [15:0] JMP_CALL_MATCH = 16'h940C;

    localparam int unsigned DEF_RESET_PC = 0;

    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & LDS_STS_MASK) == LDS_STS_MATCH) ||
               ((w & JMP_CALL_MASK) == JMP_CALL_MATCH);
    endfunction

endpackage

// File: rtl/avr_two_word_detect.sv
// Flags 16-bit opcodes that are followed by a second instruction word.
// Latency: purely combinational.
// Backpressure: none.
// Ports: word (opcode in), is_two (high for LDS/STS/JMP/CALL).
module avr_two_word_detect
    import prog_fetch_pkg::*;
(
    input  logic [15:0] word,
    output logic        is_two
);

    assign is_two = is_two_word(word);

endmodule

// File: rtl/prog_fetch_ctrl.sv
// Program-ROM sequencer: byte-wise image load, then word fetch to the decoder.
// Latency: 2 cycles FETCH->instr_valid for one-word opcodes, 4 for two-word.
// Backpressure: instr/instr2 held in S_VALID until instr_ack; halt overrides.
// Ports: clk/clr_n; start/halt control; load_* byte stream in, load_ready out;
//        rom_* ROM read/write port; instr*/pc/busy to the decoder.
module prog_fetch_ctrl
    import prog_fetch_pkg::*;
#(
    parameter int              PC_W     = 14,
    parameter int              ADDR_W   = 15,   // byte address, PC_W+1
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              halt,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_done,
    output logic              load_ready,
    input  logic              instr_ack,
    input  logic              pc_load,
    input  logic [PC_W-1:0]   pc_load_val,
    input  logic [7:0]        rom_qa,
    input  logic [7:0]        rom_qb,
    output logic [ADDR_W-1:0] rom_addr_a,
    output logic [ADDR_W-1:0] rom_addr_b,
    output logic              rom_en_reg,
    output logic              rom_clr_reg_n,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_write_addr,
    output logic [7:0]        rom_data,
    output logic [15:0]       instr,
    output logic [15:0]       instr2,
    output logic              instr_two,
    output logic              instr_valid,
    output logic [PC_W-1:0]   pc,
    output logic              busy
);

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [ADDR_W-1:0] wcnt, wcnt_nxt;
    logic [15:0]       instr_nxt, instr2_nxt;
    logic              instr_two_nxt;
    logic [15:0]       rom_word;
    logic              rom_two;

    // Port A reads the high byte, port B the low byte of the same word.
    assign rom_word = {rom_qa, rom_qb};

    avr_two_word_detect u_two_word_detect (
        .word   (rom_word),
        .is_two (rom_two)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            wcnt      <= '0;
            instr     <= '0;
            instr2    <= '0;
            instr_two <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            wcnt      <= wcnt_nxt;
            instr     <= instr_nxt;
            instr2    <= instr2_nxt;
            instr_two <= instr_two_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        wcnt_nxt      = wcnt;
        instr_nxt     = instr;
        instr2_nxt    = instr2;
        instr_two_nxt = instr_two;

        // halt wins over everything outside a load, freezing pc and the
        // instruction registers where they are.
        if (halt && state != S_LOAD) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state_nxt = S_LOAD;
                        wcnt_nxt  = '0;
                    end else if (start) begin
                        state_nxt = S_FETCH;
                        pc_nxt    = RESET_PC;
                    end
                end
                S_LOAD: begin
                    // The counter wraps naturally at the top of the byte space.
                    if (load_valid) wcnt_nxt = wcnt + ADDR_W'(1);
                    if (load_done)  state_nxt = S_IDLE;
                end
                S_FETCH:  state_nxt = S_CHK;
                S_CHK: begin
                    instr_nxt = rom_word;
                    pc_nxt    = pc + PC_W'(1);
                    if (rom_two) begin
                        state_nxt = S_FETCH2;
                    end else begin
                        instr2_nxt    = '0;
                        instr_two_nxt = 1'b0;
                        state_nxt     = S_VALID;
                    end
                end
                S_FETCH2: state_nxt = S_CHK2;
                S_CHK2: begin
                    instr2_nxt    = rom_word;
                    instr_two_nxt = 1'b1;
                    pc_nxt        = pc + PC_W'(1);
                    state_nxt     = S_VALID;
                end
                S_VALID: begin
                    if (instr_ack) begin
                        if (pc_load) pc_nxt = pc_load_val;
                        state_nxt = S_FETCH;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign load_ready     = (state == S_LOAD);
    assign rom_we         = load_ready & load_valid;
    assign rom_write_addr = wcnt;
    assign rom_data       = load_data;

    assign rom_addr_a     = {pc, 1'b1};
    assign rom_addr_b     = {pc, 1'b0};
    assign rom_en_reg     = (state == S_FETCH) || (state == S_FETCH2);
    // Gated with clr_n so the ROM register clears the moment reset asserts.
    assign rom_clr_reg_n  = clr_n & ~((state == S_IDLE) || (state == S_LOAD));

    assign instr_valid    = (state == S_VALID);
    assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// Bench for prog_fetch_ctrl with a dual-port byte ROM model and an
// instruction-level reference model of fetch, two-word decode and pc.
module tb_prog_fetch_ctrl;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0, halt = 1'b0;
    logic        load_start = 1'b0, load_valid = 1'b0, load_done = 1'b0;
    logic [7:0]  load_data = 8'h00;
    logic        load_ready;
    logic        instr_ack = 1'b0, pc_load = 1'b0;
    logic [13:0] pc_load_val = 14'h0;
    logic [7:0]  rom_qa = 8'h00, rom_qb = 8'h00;
    logic [14:0] rom_addr_a, rom_addr_b, rom_write_addr;
    logic        rom_en_reg, rom_clr_reg_n, rom_we;
    logic [7:0]  rom_data;
    logic [15:0] instr, instr2;
    logic        instr_two, instr_valid, busy;
    logic [13:0] pc;

    int n_checks = 0;
    int n_fail   = 0;

    // ROM contents; bd_* is a bench-side preload path.
    bit   [7:0]  mem [0:32767];
    logic        bd_we = 1'b0;
    logic [13:0] bd_addr = 14'h0;
    logic [15:0] bd_word = 16'h0;

    // Reference model state: word address of the next instruction.
    logic [13:0] mp;

    always #5 clk = ~clk;

    prog_fetch_ctrl #(.PC_W(14), .ADDR_W(15), .RESET_PC(14'h0)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .halt(halt),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_done(load_done), .load_ready(load_ready),
        .instr_ack(instr_ack), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .rom_qa(rom_qa), .rom_qb(rom_qb),
        .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
        .rom_en_reg(rom_en_reg), .rom_clr_reg_n(rom_clr_reg_n),
        .rom_we(rom_we), .rom_write_addr(rom_write_addr), .rom_data(rom_data),
        .instr(instr), .instr2(instr2), .instr_two(instr_two),
        .instr_valid(instr_valid), .pc(pc), .busy(busy)
    );

    always @(posedge clk) begin
        if (rom_we) mem[rom_write_addr] <= rom_data;
        if (bd_we) begin
            mem[{bd_addr, 1'b1}] <= bd_word[15:8];
            mem[{bd_addr, 1'b0}] <= bd_word[7:0];
        end
        if (!rom_clr_reg_n) begin
            rom_qa <= 8'h00;
            rom_qb <= 8'h00;
        end else if (rom_en_reg) begin
            rom_qa <= mem[rom_addr_a];
            rom_qb <= mem[rom_addr_b];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [13:0] a);
        logic [14:0] hi, lo;
        hi = {a, 1'b1};
        lo = {a, 1'b0};
        return {mem[hi], mem[lo]};
    endfunction

    // Opcode classes written from field layout: LDS/STS = 1001_00xx_xxxx_0000,
    // JMP/CALL = 1001_010x_xxxx_11xx.
    function automatic logic ref_two(input logic [15:0] w);
        return (w[15:10] == 6'b100100 && w[3:0] == 4'h0) ||
               (w[15:9] == 7'b1001010 && w[3:2] == 2'b11);
    endfunction

    task automatic bd_write(input logic [13:0] a, input logic [15:0] w);
        bd_addr = a;
        bd_word = w;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mp = 14'h0;
    endtask

    task automatic do_halt();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("halt_idle", busy, 1'b0);
    endtask

    // Entered one half-cycle after the DUT moved into the fetch state.
    task automatic fetch_to_valid(output logic [15:0] e_i, output logic [13:0] e_pc);
        logic [15:0] w1, e_i2;
        logic        e_two;
        logic [13:0] p1;
        int          n;
        p1    = mp + 14'd1;
        w1    = word_at(mp);
        e_two = ref_two(w1);
        e_i   = w1;
        e_i2  = e_two ? word_at(p1) : 16'h0;
        e_pc  = e_two ? mp + 14'd2 : p1;
        chk("fetch_en", rom_en_reg, 1'b1);
        chk("fetch_addr_b", rom_addr_b, {mp, 1'b0});
        chk("fetch_addr_a", rom_addr_a, {mp, 1'b1});
        n = 0;
        while (!instr_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, e_two ? 4 : 2);
        chk("instr", instr, e_i);
        chk("instr2", instr2, e_i2);
        chk("instr_two", instr_two, e_two);
        chk("pc_valid", pc, e_pc);
        chk("en_valid", rom_en_reg, 1'b0);
    endtask

    task automatic run_one(input bit pl, input logic [13:0] t, input int hold);
        logic [15:0] e_i;
        logic [13:0] e_pc;
        fetch_to_valid(e_i, e_pc);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", instr_valid, 1'b1);
            chk("hold_instr", instr, e_i);
        end
        instr_ack   = 1'b1;
        pc_load     = pl;
        pc_load_val = t;
        @(negedge clk);
        instr_ack = 1'b0;
        pc_load   = 1'b0;
        mp = pl ? t : e_pc;
    endtask

    // Reaches S_VALID, then asserts halt together with ack and redirect.
    task automatic halt_at_valid();
        logic [15:0] e_i;
        logic [13:0] e_pc;
        fetch_to_valid(e_i, e_pc);
        halt        = 1'b1;
        instr_ack   = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 14'h0100;
        @(negedge clk);
        halt = 1'b0; instr_ack = 1'b0; pc_load = 1'b0;
        chk("halt_busy", busy, 1'b0);
        chk("halt_valid", instr_valid, 1'b0);
        chk("halt_pc", pc, e_pc);
        chk("halt_clr", rom_clr_reg_n, 1'b0);
        @(negedge clk);
        chk("halt_stay", busy, 1'b0);
    endtask

    task automatic load_bytes(input logic [7:0] b [4], input int cnt, input bit hold_halt);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        halt  = hold_halt;
        start = hold_halt;
        chk("load_ready", load_ready, 1'b1);
        chk("load_clr", rom_clr_reg_n, 1'b0);
        for (int i = 0; i < cnt; i++) begin
            load_valid = 1'b1;
            load_data  = b[i];
            load_done  = (i == cnt - 1);
            #1;
            chk("load_we", rom_we, 1'b1);
            chk("load_addr", rom_write_addr, i);
            chk("load_data", rom_data, b[i]);
            @(negedge clk);
            if (i == 0) begin
                // idle gap mid-stream: no write, still loading
                load_valid = 1'b0;
                #1;
                chk("load_gap_we", rom_we, 1'b0);
                chk("load_gap_rdy", load_ready, 1'b1);
                @(negedge clk);
            end
        end
        load_valid = 1'b0;
        load_done  = 1'b0;
        halt  = 1'b0;
        start = 1'b0;
        #1;
        chk("load_end_rdy", load_ready, 1'b0);
        chk("load_end_busy", busy, 1'b0);
        chk("load_end_we", rom_we, 1'b0);
        chk("load_wcnt", rom_write_addr, cnt);
    endtask

    initial begin
        logic [7:0] img [4];
        logic [13:0] t;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 16'h0);
        chk("rst_instr2", instr2, 16'h0);
        chk("rst_two", instr_two, 1'b0);
        chk("rst_pc", pc, 14'h0);
        chk("rst_we", rom_we, 1'b0);
        chk("rst_en", rom_en_reg, 1'b0);
        chk("rst_clr", rom_clr_reg_n, 1'b0);
        chk("rst_ready", load_ready, 1'b0);
        clr_n = 1'b1;
        @(negedge clk);

        // Program load of JMP 0x1234
        img = '{8'h0C, 8'h94, 8'h34, 8'h12};
        load_bytes(img, 4, 1'b0);
        @(negedge clk);
        chk("rb0", mem[0], 8'h0C);
        chk("rb1", mem[1], 8'h94);
        chk("rb2", mem[2], 8'h34);
        chk("rb3", mem[3], 8'h12);

        // halt and start ignored during a load
        img = '{8'h0C, 8'h94, 8'h00, 8'h00};
        load_bytes(img, 2, 1'b1);
        @(negedge clk);
        chk("rb_halt0", mem[0], 8'h0C);
        chk("rb_halt1", mem[1], 8'h94);

        // NOP with a stalled decoder
        bd_write(14'h0, 16'h0000);
        do_start();
        run_one(1'b0, 14'h0, 5);
        do_halt();

        // JMP with redirect
        bd_write(14'h0, 16'h940C);
        bd_write(14'h1, 16'h1234);
        do_start();
        run_one(1'b1, 14'h1234, 0);
        chk("redirect_addr", rom_addr_b, 15'h2468);
        run_one(1'b0, 14'h0, 1);
        do_halt();

        // Two-word opcode at the top of the address space
        bd_write(14'h3FFF, 16'h9100);
        bd_write(14'h0, 16'hABCD);
        do_start();
        run_one(1'b1, 14'h3FFF, 0);
        run_one(1'b0, 14'h0, 0);
        chk("wrap_mp", mp, 14'h0001);
        do_halt();

        // halt beats ack and redirect
        do_start();
        halt_at_valid();

        // Asynchronous reset while in the second fetch
        bd_write(14'h0, 16'h940C);
        bd_write(14'h1, 16'h1234);
        do_start();
        @(negedge clk);
        @(negedge clk);
        chk("f2_en", rom_en_reg, 1'b1);
        chk("f2_addr", rom_addr_b, 15'h0002);
        chk("f2_instr", instr, 16'h940C);
        #2 clr_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_instr", instr, 16'h0);
        chk("arst_instr2", instr2, 16'h0);
        chk("arst_two", instr_two, 1'b0);
        chk("arst_pc", pc, 14'h0);
        chk("arst_en", rom_en_reg, 1'b0);
        chk("arst_clr", rom_clr_reg_n, 1'b0);
        chk("arst_valid", instr_valid, 1'b0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        do_start();
        run_one(1'b0, 14'h0, 0);
        do_halt();

        // Random programs in words 0..15 with random stalls, redirects, halts
        for (int a = 0; a < 16; a++) begin
            logic [15:0] w;
            case ($urandom_range(0, 3))
                0:       w = (16'($urandom) & 16'h03F0) | 16'h9000;
                1:       w = (16'($urandom) & 16'h01F3) | 16'h940C;
                default: w = 16'($urandom);
            endcase
            bd_write(14'(a), w);
        end
        do_start();
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                halt_at_valid();
                do_start();
            end else begin
                t = 14'($urandom_range(0, 15));
                run_one($urandom_range(0, 3) == 0, t, $urandom_range(0, 3));
            end
        end
        do_halt();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
